// File: rtl/tracker_pkg.sv
// Shared types and constants for the fitness-tracker step datapath.
// TRACKER_HIACT_EN (when defined) enables the high-activity display mode in users of this package.
package tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        STEPS = 2'd0,
        DIST  = 2'd1,
        HIACT = 2'd2
    } disp_mode_t;

    localparam int unsigned STEPS_PER_MILE_LOG2 = 11;
    localparam int unsigned SAT_LIMIT_DEFAULT   = 9999;

    // Clamp a 16-bit value to the largest value the display can show.
    function automatic logic [15:0] satClip(input logic [15:0] value, input int unsigned limit);
        return (32'(value) > limit) ? 16'(limit) : value;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running period timer: counts 0..TICK_CYCLES-1 while enabled, holds otherwise.
// sec_tick is high on the terminal count of an enabled cycle; used by the tracker timers.
module tick_gen
    import tracker_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sec_tick
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    // Gating with en keeps a paused timer parked on its terminal count silent.
    assign sec_tick = en && (count == LAST);

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/step_tracker_ctrl.sv
// Step-counter control, per-second step rate, high-activity time and display multiplexing.
// Define TRACKER_HIACT_EN to build the high-activity logic and the third (HIACT) display mode.
module step_tracker_ctrl
    import tracker_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 100_000_000,
    parameter int unsigned DISP_SECONDS = 2,
    parameter int unsigned HI_THRESH    = 64,
    parameter int unsigned SAT_LIMIT    = SAT_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step_in,
    input  logic [15:0] step_count,
    output logic        cnt_start,
    output logic        cnt_reset,
    output logic [1:0]  disp_mode,
    output logic [15:0] disp_value,
    output logic        si,
    output logic        sec_tick
);

    localparam int unsigned DSW = (DISP_SECONDS > 1) ? $clog2(DISP_SECONDS) : 1;
    localparam logic [DSW-1:0] DISP_LAST = DSW'(DISP_SECONDS - 1);
    localparam int unsigned HALF_MILE_SHIFT = STEPS_PER_MILE_LOG2 - 1;

    ctrl_state_t    state;
    disp_mode_t     modeReg;
    disp_mode_t     modeNext;
    logic           resetQ;
    logic           running;
    logic           step_in_q;
    logic           step_rise;
    logic [7:0]     sps_cnt;
    logic [DSW-1:0] disp_sec;

    assign running   = (state == RUN);
    assign step_rise = step_in & ~step_in_q;
    assign si        = 32'(step_count) > SAT_LIMIT;
    assign cnt_reset = reset | resetQ;
    assign disp_mode = modeReg;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) secTimer (
        .clk     (clk),
        .reset   (reset),
        .en      (running),
        .sec_tick(sec_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt_start <= 1'b0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (start) begin
                        state     <= RUN;
                        cnt_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state     <= PAUSE;
                        cnt_start <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt_start <= 1'b0;
                end
            endcase
        end
    end

    // Stretches the counter clear over the first IDLE cycle after reset releases.
    always_ff @(posedge clk) begin
        resetQ <= reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_in_q <= 1'b0;
            sps_cnt   <= '0;
        end else begin
            step_in_q <= step_in;
            if (sec_tick) begin
                sps_cnt <= {7'd0, step_rise};
            end else if (running && step_rise && (sps_cnt != 8'hFF)) begin
                sps_cnt <= sps_cnt + 8'd1;
            end
        end
    end

`ifdef TRACKER_HIACT_EN
    logic [15:0] hiact_sec;

    // The closing second is judged on sps_cnt before this cycle's edge is folded in.
    always_ff @(posedge clk) begin
        if (reset) begin
            hiact_sec <= '0;
        end else if (sec_tick && (32'(sps_cnt) >= HI_THRESH) && (hiact_sec != 16'hFFFF)) begin
            hiact_sec <= hiact_sec + 16'd1;
        end
    end
`endif

    // NOTE: modeNext gets a default first so no path through this block infers a latch.
    always_comb begin
        modeNext = modeReg;
        if (state == IDLE) begin
            modeNext = STEPS;
        end else if (sec_tick && (disp_sec == DISP_LAST)) begin
            case (modeReg)
                STEPS: modeNext = DIST;
`ifdef TRACKER_HIACT_EN
                DIST:  modeNext = HIACT;
`endif
                default: modeNext = STEPS;
            endcase
        end
    end

    // disp_value follows modeNext so mode and value always change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            modeReg    <= STEPS;
            disp_sec   <= '0;
            disp_value <= '0;
        end else begin
            modeReg <= modeNext;
            if (state == IDLE) begin
                disp_sec <= '0;
            end else if (sec_tick) begin
                disp_sec <= (disp_sec == DISP_LAST) ? '0 : disp_sec + 1'b1;
            end
            case (modeNext)
                STEPS:   disp_value <= satClip(step_count, SAT_LIMIT);
                DIST:    disp_value <= step_count >> HALF_MILE_SHIFT;
`ifdef TRACKER_HIACT_EN
                HIACT:   disp_value <= satClip(hiact_sec, SAT_LIMIT);
`endif
                default: disp_value <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_step_tracker_ctrl.sv
// Self-checking bench for step_tracker_ctrl: vector table, directed sequences, random run vs model.
// Works with TRACKER_HIACT_EN either defined or undefined.
module tb_step_tracker_ctrl;

    localparam int T   = 10;
    localparam int D   = 2;
    localparam int HI  = 3;
    localparam int SAT = 9999;
`ifdef TRACKER_HIACT_EN
    localparam int NM       = 3;
    localparam bit HIACT_ON = 1'b1;
`else
    localparam int NM       = 2;
    localparam bit HIACT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        step_in;
    logic [15:0] step_count;
    logic        cnt_start;
    logic        cnt_reset;
    logic [1:0]  disp_mode;
    logic [15:0] disp_value;
    logic        si;
    logic        sec_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    step_tracker_ctrl #(
        .TICK_CYCLES (T),
        .DISP_SECONDS(D),
        .HI_THRESH   (HI),
        .SAT_LIMIT   (SAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_in   (step_in),
        .step_count(step_count),
        .cnt_start (cnt_start),
        .cnt_reset (cnt_reset),
        .disp_mode (disp_mode),
        .disp_value(disp_value),
        .si        (si),
        .sec_tick  (sec_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tickIn();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Works from cumulative quantities: RUN cycles elapsed, seconds completed and steps per second.
    // Each negedge it predicts the outputs that follow the coming posedge.
    int mState;       // 0 idle, 1 run, 2 pause
    int runCyc;
    int done;
    int hiact;
    int mMode;
    int mValue;
    bit mCntStart;
    bit prevStep;
    bit lastReset;
    bit modelOn = 1'b0;
    int stepsIn [int];

    task automatic modelStep();
        bit rise;
        bit tick;
        int hOld;
        int sec;
        int sc;
        if (reset) begin
            mState = 0; runCyc = 0; done = 0; hiact = 0; stepsIn.delete();
            prevStep = 1'b0; mMode = 0; mValue = 0; mCntStart = 1'b0; modelOn = 1'b1;
        end else begin
            tick = (mState == 1) && (runCyc % T == T - 1);
            rise = step_in && !prevStep;
            hOld = hiact;
            if (mState == 1 && rise) begin
                // An edge on the last cycle of a second belongs to the next one.
                sec = (runCyc + 1) / T;
                stepsIn[sec] = (stepsIn.exists(sec) ? stepsIn[sec] : 0) + 1;
            end
            if (tick) begin
                if (stepsIn.exists(done) && stepsIn[done] >= HI && hiact < 65535) hiact++;
                done++;
            end
            if (mState == 1) runCyc++;
            mMode = (done / D) % NM;
            sc = int'(step_count);
            case (mMode)
                0:       mValue = (sc > SAT) ? SAT : sc;
                1:       mValue = sc / 1024;
                default: mValue = (hOld > SAT) ? SAT : hOld;
            endcase
            mState    = start ? 1 : ((mState == 0) ? 0 : 2);
            mCntStart = (mState == 1);
            prevStep  = step_in;
        end
        lastReset = reset;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (modelOn) begin
                check("m_cnt_start", cnt_start, mCntStart);
                check("m_cnt_reset", cnt_reset, reset | lastReset);
                check("m_disp_mode", disp_mode, mMode);
                check("m_disp_value", disp_value, mValue);
                check("m_si", si, step_count > SAT);
                check("m_sec_tick", sec_tick, (mState == 1) && (runCyc % T == T - 1));
            end
            modelStep();
        end
    end

    // ---------------- directed and random stimulus ----------------
    typedef struct packed {
        logic [15:0] sc;
        logic        siExp;
        logic [15:0] dvExp;
    } vec_t;

    initial begin
        vec_t vecs [8];
        logic stepPlan;

        vecs[0] = '{16'd0,     1'b0, 16'd0};
        vecs[1] = '{16'd1,     1'b0, 16'd1};
        vecs[2] = '{16'd4096,  1'b0, 16'd4096};
        vecs[3] = '{16'd9998,  1'b0, 16'd9998};
        vecs[4] = '{16'd9999,  1'b0, 16'd9999};
        vecs[5] = '{16'd10000, 1'b1, 16'd9999};
        vecs[6] = '{16'd12000, 1'b1, 16'd9999};
        vecs[7] = '{16'd65535, 1'b1, 16'd9999};

        reset = 1'b1; start = 1'b0; step_in = 1'b0; step_count = 16'd0;

        // Reset held for three edges.
        tickIn();
        tickIn();
        @(negedge clk);
        check("rst_cnt_start", cnt_start, 0);
        check("rst_cnt_reset", cnt_reset, 1);
        check("rst_disp_mode", disp_mode, 0);
        check("rst_disp_value", disp_value, 0);
        check("rst_si", si, 0);
        check("rst_sec_tick", sec_tick, 0);
        tickIn();
        reset = 1'b0;
        @(negedge clk);
        check("idle1_cnt_reset", cnt_reset, 1);
        tickIn();
        @(negedge clk);
        check("idle2_cnt_reset", cnt_reset, 0);

        // Saturation and overflow table, in IDLE where the display is forced to STEPS.
        for (int i = 0; i < 8; i++) begin
            tickIn();
            step_count = vecs[i].sc;
            @(negedge clk);
            check($sformatf("vec%0d_si", i), si, vecs[i].siExp);
            tickIn();
            @(negedge clk);
            check($sformatf("vec%0d_value", i), disp_value, vecs[i].dvExp);
            check($sformatf("vec%0d_mode", i), disp_mode, 0);
        end

        // Run: 3 edges in second 1, 2 in second 2, and an edge on the tick closing second 3.
        tickIn();
        step_count = 16'd4096;
        start = 1'b1;
        @(negedge clk);
        check("start_lat_cnt_start", cnt_start, 0);
        for (int r = 1; r <= 85; r++) begin
            tickIn();
            stepPlan = (r == 2) || (r == 4) || (r == 6) || (r == 12) || (r == 14) ||
                       (r == 30) || (r == 32) || (r == 34);
            step_in = stepPlan;
            if (r == 85) start = 1'b0;
            @(negedge clk);
            if (r == 1)  check("run1_cnt_start", cnt_start, 1);
            if (r == 9)  check("run9_no_tick", sec_tick, 0);
            if (r == 10) check("run10_tick", sec_tick, 1);
            if (r == 20) check("run20_mode", disp_mode, 0);
            if (r == 21) begin
                check("run21_mode", disp_mode, 1);
                check("run21_dist", disp_value, 4);
            end
            if (r == 41) begin
                check("run41_mode", disp_mode, HIACT_ON ? 2 : 0);
                check("run41_value", disp_value, HIACT_ON ? 1 : 4096);
            end
            if (r == 45) check("run45_value", disp_value, HIACT_ON ? 2 : 4096);
            if (r == 61) begin
                check("run61_mode", disp_mode, HIACT_ON ? 0 : 1);
                check("run61_value", disp_value, HIACT_ON ? 4096 : 4);
            end
        end

        // Pause 5 cycles into a second; the partial second must resume, not restart.
        for (int j = 1; j <= 50; j++) begin
            tickIn();
            if (j == 50) start = 1'b1;
            @(negedge clk);
            check("pause_sec_tick", sec_tick, 0);
            check("pause_cnt_start", cnt_start, 0);
        end
        for (int k = 1; k <= 5; k++) begin
            tickIn();
            @(negedge clk);
            check($sformatf("resume%0d_sec_tick", k), sec_tick, k == 5);
            if (k == 1) check("resume_cnt_start", cnt_start, 1);
        end

        // Random traffic against the model, with occasional mid-second resets.
        for (int n = 0; n < 3000; n++) begin
            tickIn();
            reset   = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 9) != 0);
            step_in = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       step_count = 16'($urandom_range(0, 65535));
                1:       step_count = 16'($urandom_range(9990, 10010));
                default: step_count = 16'($urandom_range(0, 9999));
            endcase
        end
        tickIn();
        reset = 1'b0;
        tickIn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
